tmr_retry_buffer: RTL and testbench

Retry buffer placed directly upstream of `time_TMR_start`, in the same time-redundant path.
- Assigns each accepted item a slot ID and keeps a copy until the end of the redundant path reports it.
- On a fault report for an ID, replays the stored copy.
- Gives the TMR start/end pair a recovery path for faults that voting cannot correct, e.g. three disagreeing copies or a lock timeout.

---
 rtl/tmr_retry_buffer.sv | 137 +++++++++++++
 tb/tb_tmr_retry_buffer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_retry_buffer.sv
// Retry buffer ahead of time_TMR_start: tags each item with a slot ID, keeps a copy
// until the redundant path reports it, and replays on fault. TMR_RETRY_LIMIT_EN caps replays.
module tmr_retry_buffer #(
    parameter type DataType   = logic,
    parameter int  IDSize     = 2,
    parameter int  MaxRetries = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  DataType           data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output DataType           data_o,
    output logic [IDSize-1:0] id_o,
    output logic              valid_o,
    input  logic              ready_i,
    input  logic [IDSize-1:0] fb_id_i,
    input  logic              fb_fault_i,
    input  logic              fb_valid_i,
    output logic              fb_ready_o,
    output logic              drop_o
);
    localparam int Depth = 2 ** IDSize;

    if (MaxRetries < 0) begin : g_bad_max_retries
        $error("MaxRetries must be non-negative");
    end

    // Every port pair transfers on a clock edge where valid and ready are both high;
    // valid never waits on ready, and the output register holds steady while stalled.
    logic [Depth-1:0]  busy;
    logic [Depth-1:0]  busy_next;
    DataType           slot_data [Depth];
    logic [IDSize-1:0] next_id;
    logic              replay_pending;
    logic [IDSize-1:0] replay_id;
    DataType           data_q;
    logic [IDSize-1:0] id_q;
    logic              valid_q;

    logic out_free;
    logic accept;
    logic fb_fire;
    logic fb_hit;
    logic replay_fire;
    logic give_up;

    assign out_free    = !valid_q || ready_i;
    assign ready_o     = !busy[next_id] && !replay_pending && out_free;
    assign fb_ready_o  = !replay_pending;
    assign accept      = valid_i && ready_o;
    assign fb_fire     = fb_valid_i && fb_ready_o;
    assign fb_hit      = fb_fire && busy[fb_id_i];
    assign replay_fire = replay_pending && out_free;

    assign data_o  = data_q;
    assign id_o    = id_q;
    assign valid_o = valid_q;

`ifdef TMR_RETRY_LIMIT_EN
    localparam int CntWidth = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

    logic [CntWidth-1:0] retry_cnt [Depth];
    logic                drop_q;

    assign give_up = fb_hit && fb_fault_i && (retry_cnt[fb_id_i] == CntWidth'(MaxRetries));
    assign drop_o  = drop_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_q <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                retry_cnt[i] <= '0;
            end
        end else begin
            drop_q <= give_up;
            if (accept) begin
                retry_cnt[next_id] <= '0;
            end
            if (fb_hit && fb_fault_i && !give_up) begin
                retry_cnt[fb_id_i] <= retry_cnt[fb_id_i] + 1'b1;
            end
        end
    end
`else
    assign give_up = 1'b0;
    assign drop_o  = 1'b0;
`endif

    // Allocate and free never touch the same slot: one needs it idle, the other busy.
    always_comb begin
        busy_next = busy;
        if (accept) begin
            busy_next[next_id] = 1'b1;
        end
        if (fb_hit && (!fb_fault_i || give_up)) begin
            busy_next[fb_id_i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            slot_data[next_id] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy           <= '0;
            next_id        <= '0;
            replay_pending <= 1'b0;
            replay_id      <= '0;
            data_q         <= '0;
            id_q           <= '0;
            valid_q        <= 1'b0;
        end else begin
            busy <= busy_next;
            if (accept) begin
                data_q  <= data_i;
                id_q    <= next_id;
                valid_q <= 1'b1;
                next_id <= next_id + 1'b1;
            end else if (replay_fire) begin
                data_q         <= slot_data[replay_id];
                id_q           <= replay_id;
                valid_q        <= 1'b1;
                replay_pending <= 1'b0;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
            if (fb_hit && fb_fault_i && !give_up) begin
                replay_pending <= 1'b1;
                replay_id      <= fb_id_i;
            end
        end
    end
endmodule

// File: tb/tb_tmr_retry_buffer.sv
// Bench for tmr_retry_buffer: directed vector table, hand-written corner sequences,
// then random traffic against a slot-level reference model.
module tb_tmr_retry_buffer;
    localparam int MAXR = 2;
`ifdef TMR_RETRY_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_o;
    logic [1:0] id_o;
    logic       valid_o;
    logic       ready_i;
    logic [1:0] fb_id_i;
    logic       fb_fault_i;
    logic       fb_valid_i;
    logic       fb_ready_o;
    logic       drop_o;

    int n_vec = 0;
    int n_err = 0;

    tmr_retry_buffer #(
        .DataType  (logic [7:0]),
        .IDSize    (2),
        .MaxRetries(MAXR)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data_o    (data_o),
        .id_o      (id_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .fb_id_i   (fb_id_i),
        .fb_fault_i(fb_fault_i),
        .fb_valid_i(fb_valid_i),
        .fb_ready_o(fb_ready_o),
        .drop_o    (drop_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic vi, input logic [7:0] d, input logic rdy,
                         input logic fbv, input logic [1:0] fbid, input logic fbf);
        valid_i    = vi;
        data_i     = d;
        ready_i    = rdy;
        fb_valid_i = fbv;
        fb_id_i    = fbid;
        fb_fault_i = fbf;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Reference model: slot table plus one output item.
    logic       m_busy [4];
    logic [7:0] m_data [4];
    int         m_cnt  [4];
    int         m_next;
    bit         m_rp;
    int         m_rid;
    bit         m_valid;
    logic [7:0] m_dout;
    int         m_idout;
    bit         m_drop;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_busy[i] = 1'b0;
            m_cnt[i]  = 0;
        end
        m_next  = 0;
        m_rp    = 1'b0;
        m_rid   = 0;
        m_valid = 1'b0;
        m_dout  = 8'h00;
        m_idout = 0;
        m_drop  = 1'b0;
    endfunction

    function automatic bit model_ready(input bit rdy);
        return !m_busy[m_next] && !m_rp && (!m_valid || rdy);
    endfunction

    function automatic void model_step(input bit vi, input logic [7:0] d, input bit rdy,
                                       input bit fbv, input int fbid, input bit fbf);
        bit can_take = model_ready(rdy);
        bit can_out  = !m_valid || rdy;
        bit fb_ok    = fbv && !m_rp && m_busy[fbid];
        bit had_rp   = m_rp;
        m_drop = 1'b0;
        if (vi && can_take) begin
            m_data[m_next] = d;
            m_busy[m_next] = 1'b1;
            m_cnt[m_next]  = 0;
            m_dout  = d;
            m_idout = m_next;
            m_valid = 1'b1;
            m_next  = (m_next + 1) % 4;
        end else if (had_rp && can_out) begin
            m_dout  = m_data[m_rid];
            m_idout = m_rid;
            m_valid = 1'b1;
            m_rp    = 1'b0;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        if (fb_ok) begin
            if (!fbf) begin
                m_busy[fbid] = 1'b0;
            end else if (LIMIT_EN && m_cnt[fbid] == MAXR) begin
                m_busy[fbid] = 1'b0;
                m_drop = 1'b1;
            end else begin
                m_cnt[fbid]++;
                m_rp  = 1'b1;
                m_rid = fbid;
            end
        end
    endfunction

    typedef struct {
        logic       vi;
        logic [7:0] d;
        logic       rdy;
        logic       fbv;
        logic [1:0] fbid;
        logic       fbf;
        logic       e_valid;
        logic [7:0] e_data;
        logic [1:0] e_id;
        logic       e_ready;
        logic       e_fbr;
    } vec_t;

    vec_t tbl [15];

    initial begin
        // ordered issue, full/free, fault replay with one-cycle input stall
        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b1};
        tbl[1]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'hA5, 2'd0, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, 8'h7E, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h3C, 2'd1, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 8'h11, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h7E, 2'd2, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 8'h22, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h11, 2'd3, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 8'h22, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 8'h22, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 8'h22, 2'd0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 8'h3C, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 8'h44, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 8'h3C, 2'd1, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 8'h55, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h44, 2'd2, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 8'h55, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h3C, 2'd1, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h55, 2'd3, 1'b0, 1'b1};

        // reset values
        do_reset();
        settle();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_id", 32'(id_o), 32'd0);
        chk("rst_drop", 32'(drop_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_fb_ready", 32'(fb_ready_o), 32'd1);
        tick();

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].vi, tbl[i].d, tbl[i].rdy, tbl[i].fbv, tbl[i].fbid, tbl[i].fbf);
            settle();
            chk($sformatf("tbl%0d_valid", i), 32'(valid_o), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_ready", i), 32'(ready_o), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_fb_ready", i), 32'(fb_ready_o), 32'(tbl[i].e_fbr));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_data", i), 32'(data_o), 32'(tbl[i].e_data));
                chk($sformatf("tbl%0d_id", i), 32'(id_o), 32'(tbl[i].e_id));
            end
            tick();
        end

        // backpressure: output holds, input stalls, then full rate again
        do_reset();
        drive(1'b1, 8'hA1, 1'b1, 1'b0, 2'd0, 1'b0);
        settle();
        chk("bp_first_ready", 32'(ready_o), 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hB2, 1'b0, 1'b0, 2'd0, 1'b0);
            settle();
            chk("bp_hold_valid", 32'(valid_o), 32'd1);
            chk("bp_hold_data", 32'(data_o), 32'hA1);
            chk("bp_hold_id", 32'(id_o), 32'd0);
            chk("bp_hold_ready", 32'(ready_o), 32'd0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(i < 3, 8'(8'hB2 + 8'(i) * 8'h11), 1'b1, 1'b0, 2'd0, 1'b0);
            settle();
            chk("bp_rel_valid", 32'(valid_o), 32'd1);
            chk("bp_rel_data", 32'(data_o), (i == 0) ? 32'hA1 : 32'(8'hB2 + 8'(i - 1) * 8'h11));
            chk("bp_rel_id", 32'(id_o), 32'(i));
            if (i < 3) chk("bp_rel_ready", 32'(ready_o), 32'd1);
            tick();
        end

        // retry limit on slot 2
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h10 * (i + 1)), 1'b1, 1'b0, 2'd0, 1'b0);
            tick();
        end
        for (int r = 0; r < 3; r++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 1'b1);
            settle();
            chk("rl_out_valid", 32'(valid_o), 32'd1);
            chk("rl_out_data", 32'(data_o), 32'h30);
            chk("rl_out_id", 32'(id_o), 32'd2);
            chk("rl_fb_ready", 32'(fb_ready_o), 32'd1);
            tick();
            drive(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
            settle();
            chk("rl_gap_valid", 32'(valid_o), 32'd0);
            if (LIMIT_EN && r == MAXR) begin
                chk("rl_drop_pulse", 32'(drop_o), 32'd1);
                chk("rl_drop_fb_ready", 32'(fb_ready_o), 32'd1);
            end else begin
                chk("rl_no_drop", 32'(drop_o), 32'd0);
                chk("rl_pending_fb_ready", 32'(fb_ready_o), 32'd0);
            end
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
        settle();
        chk("rl_after_drop", 32'(drop_o), 32'd0);
        chk("rl_after_valid", 32'(valid_o), LIMIT_EN ? 32'd0 : 32'd1);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 1'b0);
        tick();
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 8'(8'h40 + j), 1'b1, 1'b0, 2'd0, 1'b0);
            settle();
            chk("rl_alloc_ready", 32'(ready_o), (j < 3 || LIMIT_EN) ? 32'd1 : 32'd0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
        settle();
        chk("rl_last_id", 32'(id_o), LIMIT_EN ? 32'd2 : 32'd1);
        chk("rl_last_data", 32'(data_o), LIMIT_EN ? 32'h43 : 32'h42);
        tick();

        // reset with three busy slots and a replay pending
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h60 + i), 1'b1, 1'b0, 2'd0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
        settle();
        chk("mr_pending_fb_ready", 32'(fb_ready_o), 32'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        drive(1'b1, 8'h99, 1'b1, 1'b1, 2'd1, 1'b1);
        settle();
        chk("mr_valid", 32'(valid_o), 32'd0);
        chk("mr_data", 32'(data_o), 32'd0);
        chk("mr_id", 32'(id_o), 32'd0);
        chk("mr_drop", 32'(drop_o), 32'd0);
        chk("mr_ready", 32'(ready_o), 32'd1);
        chk("mr_fb_ready", 32'(fb_ready_o), 32'd1);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
        settle();
        chk("mr_next_id", 32'(id_o), 32'd0);
        chk("mr_next_data", 32'(data_o), 32'h99);
        chk("mr_stray_ignored", 32'(fb_ready_o), 32'd1);
        tick();

        // random traffic against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit         vi   = ($urandom_range(0, 3) != 0);
            logic [7:0] d    = 8'($urandom);
            bit         rdy  = ($urandom_range(0, 3) != 0);
            bit         fbv  = ($urandom_range(0, 2) == 0);
            int         fbid = $urandom_range(0, 3);
            bit         fbf  = ($urandom_range(0, 2) == 0);
            bit         rst  = ($urandom_range(0, 299) == 0);
            drive(vi, d, rdy, fbv, 2'(fbid), fbf);
            rst_i = rst;
            settle();
            chk("rnd_ready", 32'(ready_o), 32'(model_ready(rdy)));
            chk("rnd_fb_ready", 32'(fb_ready_o), 32'(!m_rp));
            chk("rnd_valid", 32'(valid_o), 32'(m_valid));
            chk("rnd_drop", 32'(drop_o), 32'(m_drop));
            if (m_valid) begin
                chk("rnd_data", 32'(data_o), 32'(m_dout));
                chk("rnd_id", 32'(id_o), 32'(m_idout));
            end
            if (rst) model_reset();
            else model_step(vi, d, rdy, fbv, fbid, fbf);
            tick();
        end
        rst_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
